// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared types and bit positions for the FIR coefficient sequencer
//
// Contents:
//   seq_state_t    sequencer states
//   *_TGL          toggle bit positions inside cfg_ctrl
//   ST_*           field positions inside the status readback word
package fir_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_ARMED = 2'd3
  } seq_state_t;

  // cfg_ctrl toggle bits; software flips a bit to raise one event
  localparam int WR_TGL     = 16;
  localparam int COMMIT_TGL = 17;
  localparam int CLEAR_TGL  = 18;

  // status word layout
  localparam int ST_SWAP_LSB  = 0;
  localparam int ST_SWAP_W    = 16;
  localparam int ST_WRCNT_LSB = 16;
  localparam int ST_WRCNT_W   = 8;
  localparam int ST_BUSY_BIT  = 24;
  localparam int ST_ARMED_BIT = 25;
  localparam int ST_OVF_BIT   = 26;
  localparam int ST_ARMERR_BIT = 27;
  localparam int ST_ACTIVE_BIT = 28;

endpackage

// File: rtl/tgl_event_det.sv
// rtl/tgl_event_det.sv - registered toggle-change detector with post-reset priming
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   tgl    in   W toggle bits (already registered upstream)
//   evt    out  W one-cycle event flags, high where tgl differs from its previous value
module tgl_event_det #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tgl,
  output logic [W-1:0] evt
);

  logic [W-1:0] prev;
  logic         seen;
  logic         primed;

  // prev holds the reset value of the input stage during the first cycle after
  // release, so comparisons are masked until prev has captured a real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      seen   <= 1'b0;
      primed <= 1'b0;
    end else begin
      prev   <= tgl;
      seen   <= 1'b1;
      primed <= seen;
    end
  end

  assign evt = primed ? (tgl ^ prev) : '0;

endmodule

// File: rtl/fir_coeff_sequencer.sv
// rtl/fir_coeff_sequencer.sv - sequences software coefficient updates into a double-buffered FIR RAM
//
// Ports:
//   user_clk     in   fabric clock, rising edge
//   user_rst_n   in   asynchronous active-low reset
//   cfg_data     in   packed tap pair, [31:16] even tap, [15:0] odd tap
//   cfg_ctrl     in   [ADDR_W-1:0] pair address, [16] write, [17] commit, [18] clear toggles
//   sync_in      in   one-cycle vector-boundary pulse from the FIR datapath
//   coef_we      out  shadow RAM write enable
//   coef_addr    out  shadow RAM pair address
//   coef_wdata   out  shadow RAM write data
//   coef_bank    out  bank being written (always ~active_bank)
//   active_bank  out  bank the FIR reads
//   busy         out  sequencer not idle or an event pending
//   status       out  registered readback word
module fir_coeff_sequencer
  import fir_seq_pkg::*;
#(
  parameter int N_PAIRS = 32,
  parameter int ADDR_W  = 5,
  parameter int COEFF_W = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          cfg_data,
  input  logic [31:0]          cfg_ctrl,
  input  logic                 sync_in,
  output logic                 coef_we,
  output logic [ADDR_W-1:0]    coef_addr,
  output logic [2*COEFF_W-1:0] coef_wdata,
  output logic                 coef_bank,
  output logic                 active_bank,
  output logic                 busy,
  output logic [31:0]          status
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_PAIRS - 1);
  localparam logic [ADDR_W:0]   N_PAIRS_EXT = (ADDR_W + 1)'(N_PAIRS);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  // Input stage
  logic [2*COEFF_W-1:0] q_data;
  logic [ADDR_W-1:0]    q_addr;
  logic [2:0]           q_tgl;
  logic                 cfg_unused;

  assign cfg_unused = ^{cfg_ctrl, cfg_data};

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      q_data <= '0;
      q_addr <= '0;
      q_tgl  <= '0;
    end else begin
      q_data <= cfg_data[2*COEFF_W-1:0];
      q_addr <= cfg_ctrl[ADDR_W-1:0];
      q_tgl  <= cfg_ctrl[CLEAR_TGL:WR_TGL];
    end
  end

  // evt[0] write, evt[1] commit, evt[2] clear
  logic [2:0] evt;

  tgl_event_det #(.W(3)) u_tgl_event_det (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .tgl   (q_tgl),
    .evt   (evt)
  );

  seq_state_t           state, next_state;
  logic                 pend_wr, pend_cm, pend_cl;
  logic [ADDR_W-1:0]    wr_addr;
  logic [2*COEFF_W-1:0] wr_data;
  logic [ADDR_W-1:0]    act_addr;
  logic [2*COEFF_W-1:0] act_data;
  logic                 ovf_err, arm_err;
  logic                 armed_entry;
  logic                 active_r;
  logic [7:0]           wr_cnt;
  logic [15:0]          swap_cnt;
  logic [31:0]          status_r, status_nxt;
  logic                 wr_take, cl_take, cm_take, swap;
  logic                 wr_addr_ok;

  assign wr_addr_ok = ({1'b0, wr_addr} < N_PAIRS_EXT);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= ST_IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_take    = 1'b0;
    cl_take    = 1'b0;
    cm_take    = 1'b0;
    swap       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_cl) begin
          cl_take    = 1'b1;
          next_state = ST_CLEAR;
        end else if (pend_wr) begin
          // an out-of-range write is consumed here without entering WRITE
          wr_take = 1'b1;
          if (wr_addr_ok) next_state = ST_WRITE;
        end else if (pend_cm) begin
          cm_take    = 1'b1;
          next_state = ST_ARMED;
        end
      end
      ST_WRITE: next_state = ST_IDLE;
      ST_CLEAR: if (act_addr == LAST_ADDR) next_state = ST_IDLE;
      ST_ARMED: begin
        if (sync_in && !armed_entry) begin
          swap       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      pend_wr     <= 1'b0;
      pend_cm     <= 1'b0;
      pend_cl     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      act_addr    <= '0;
      act_data    <= '0;
      ovf_err     <= 1'b0;
      arm_err     <= 1'b0;
      armed_entry <= 1'b0;
      active_r    <= 1'b0;
      wr_cnt      <= '0;
      swap_cnt    <= '0;
    end else begin
      armed_entry <= cm_take;

      // Errors are cleared when a clear starts; any error raised in the
      // same cycle is written later in this block and therefore survives.
      if (cl_take) begin
        ovf_err <= 1'b0;
        arm_err <= 1'b0;
      end
      if (wr_take && !wr_addr_ok) ovf_err <= 1'b1;

      // A flag being consumed this cycle frees its slot for a new event.
      if (wr_take) pend_wr <= 1'b0;
      if (evt[0]) begin
        if (pend_wr && !wr_take) begin
          ovf_err <= 1'b1;
        end else begin
          pend_wr <= 1'b1;
          wr_addr <= q_addr;
          wr_data <= q_data;
        end
      end

      if (cl_take) pend_cl <= 1'b0;
      if (evt[2]) begin
        if (pend_cl && !cl_take) ovf_err <= 1'b1;
        else                     pend_cl <= 1'b1;
      end

      if (cm_take) pend_cm <= 1'b0;
      if (evt[1]) begin
        if (pend_cm || state == ST_ARMED) arm_err <= 1'b1;
        else                              pend_cm <= 1'b1;
      end

      if (wr_take) begin
        act_addr <= wr_addr;
        act_data <= wr_data;
      end else if (cl_take) begin
        act_addr <= '0;
      end else if (state == ST_CLEAR) begin
        act_addr <= act_addr + ADDR_ONE;
      end

      if (state == ST_WRITE) wr_cnt <= wr_cnt + 8'd1;

      if (swap) begin
        active_r <= ~active_r;
        swap_cnt <= swap_cnt + 16'd1;
      end
    end
  end

  assign busy        = (state != ST_IDLE) || pend_wr || pend_cm || pend_cl;
  assign coef_we     = (state == ST_WRITE) || (state == ST_CLEAR);
  assign coef_addr   = act_addr;
  assign coef_wdata  = (state == ST_WRITE) ? act_data : '0;
  assign active_bank = active_r;
  assign coef_bank   = ~active_r;

  always_comb begin
    status_nxt = '0;
    status_nxt[ST_SWAP_LSB +: ST_SWAP_W]   = swap_cnt;
    status_nxt[ST_WRCNT_LSB +: ST_WRCNT_W] = wr_cnt;
    status_nxt[ST_BUSY_BIT]   = busy;
    status_nxt[ST_ARMED_BIT]  = (state == ST_ARMED);
    status_nxt[ST_OVF_BIT]    = ovf_err;
    status_nxt[ST_ARMERR_BIT] = arm_err;
    status_nxt[ST_ACTIVE_BIT] = active_r;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) status_r <= '0;
    else             status_r <= status_nxt;
  end

  assign status = status_r;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// tb/tb_fir_coeff_sequencer.sv - directed scoreboard bench for fir_coeff_sequencer
module tb_fir_coeff_sequencer;

  logic        user_clk = 1'b0;
  logic        user_rst_n = 1'b0;
  logic [31:0] cfg_data = '0;
  logic [31:0] cfg_ctrl = '0;
  logic        sync_in = 1'b0;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [31:0] coef_wdata;
  logic        coef_bank;
  logic        active_bank;
  logic        busy;
  logic [31:0] status;

  int total = 0;
  int bad   = 0;
  logic [31:0] ctrl = '0;

  typedef struct packed {
    logic        bank;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  fir_coeff_sequencer #(.N_PAIRS(32), .ADDR_W(5), .COEFF_W(16)) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .cfg_data    (cfg_data),
    .cfg_ctrl    (cfg_ctrl),
    .sync_in     (sync_in),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_bank   (coef_bank),
    .active_bank (active_bank),
    .busy        (busy),
    .status      (status)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic bank, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.bank = bank;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_clear(input logic bank);
    for (int i = 0; i < 32; i++) push(bank, 5'(i), 32'h0);
  endtask

  task automatic toggle(input logic [31:0] mask);
    ctrl = ctrl ^ mask;
    cfg_ctrl = ctrl;
  endtask

  task automatic set_addr(input logic [4:0] a);
    ctrl = (ctrl & ~32'h1F) | {27'h0, a};
    cfg_ctrl = ctrl;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 400) begin
      @(negedge user_clk);
      n++;
    end
    check(tag, (n < 400), 1);
  endtask

  // Scoreboard consumer: every shadow write must match the oldest expectation.
  always @(negedge user_clk) begin
    exp_t e;
    if (user_rst_n && coef_we) begin
      check("sb_nonempty", (sb.size() != 0), 1);
      check("busy_during_we", busy, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("we_addr", coef_addr, e.addr);
        check("we_data", coef_wdata, e.data);
        check("we_bank", coef_bank, e.bank);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;

    // Reset state
    ticks(3);
    check("rst_we", coef_we, 0);
    check("rst_coef_bank", coef_bank, 1);
    check("rst_active", active_bank, 0);
    check("rst_busy", busy, 0);
    check("rst_status", status, 0);
    user_rst_n = 1'b1;
    ticks(4);

    // Single write and its latency
    cfg_data = 32'h1234ABCD;
    ctrl = 32'h00010007;
    cfg_ctrl = ctrl;
    push(1'b1, 5'd7, 32'h1234ABCD);
    @(posedge user_clk);
    @(negedge user_clk);
    check("wr_lat_e0", coef_we, 0);
    @(negedge user_clk);
    check("wr_lat_e1", coef_we, 0);
    @(negedge user_clk);
    check("wr_lat_e2", coef_we, 1);
    check("wr_lat_addr", coef_addr, 7);
    wait_idle("idle_write");
    tick();
    check("st_after_write", status, 32'h0001_0000);

    // Commit with a sync pulse in the ARMED entry cycle
    toggle(32'h1 << 17);
    ticks(3);
    check("armed_busy", busy, 1);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("entry_sync_ignored", active_bank, 0);
    check("st_armed_bit", status[25], 1);
    ticks(4);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("swap_active", active_bank, 1);
    check("swap_coef_bank", coef_bank, 0);
    tick();
    check("st_after_swap", status, 32'h1001_0001);

    // Write and clear together, then an overflowing second write
    cfg_data = 32'hCAFEF00D;
    set_addr(5'd3);
    toggle((32'h1 << 16) | (32'h1 << 18));
    push_clear(1'b0);
    push(1'b0, 5'd3, 32'hCAFEF00D);
    ticks(6);
    cfg_data = 32'hDEADBEEF;
    set_addr(5'd9);
    toggle(32'h1 << 16);
    wait_idle("idle_simul");
    tick();
    check("st_after_ovf", status, 32'h1402_0001);

    // Commit while armed, plus a write held until after the swap
    toggle(32'h1 << 17);
    ticks(6);
    cfg_data = 32'h55AA33CC;
    set_addr(5'd1);
    push(1'b1, 5'd1, 32'h55AA33CC);
    toggle((32'h1 << 16) | (32'h1 << 17));
    ticks(4);
    check("arm_err_set", status[27], 1);
    check("armed_no_write_yet", wr_addr_cnt(), 8'd2);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    wait_idle("idle_armed");
    ticks(2);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    ticks(3);
    check("st_after_armerr", status, 32'h0C03_0002);
    check("one_swap_active", active_bank, 0);

    // Clear wipes both sticky errors
    toggle(32'h1 << 18);
    push_clear(1'b1);
    wait_idle("idle_clear");
    tick();
    check("st_after_clear", status, 32'h0003_0002);

    // Swap once more so reset has a visible effect on active_bank
    toggle(32'h1 << 17);
    ticks(6);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    ticks(2);
    check("st_before_rst", status, 32'h1003_0003);

    // Reset in the middle of a clear
    toggle(32'h1 << 18);
    push_clear(1'b0);
    n = 0;
    do begin
      @(negedge user_clk);
      n++;
    end while (!(coef_we && coef_addr == 5'd12) && n < 100);
    check("reach_addr12", (n < 100), 1);
    #2;
    user_rst_n = 1'b0;
    #1;
    check("midrst_we", coef_we, 0);
    check("midrst_active", active_bank, 0);
    check("midrst_coef_bank", coef_bank, 1);
    check("midrst_busy", busy, 0);
    sb.delete();
    ctrl = ctrl | (32'h7 << 16);
    cfg_ctrl = ctrl;
    ticks(2);
    check("inrst_status", status, 0);
    user_rst_n = 1'b1;
    ticks(10);
    check("post_rst_busy", busy, 0);
    check("post_rst_status", status, 0);

    // Still functional after reset
    cfg_data = 32'h0F0F0F0F;
    set_addr(5'd31);
    toggle(32'h1 << 16);
    push(1'b1, 5'd31, 32'h0F0F0F0F);
    wait_idle("idle_final");
    tick();
    check("st_final", status, 32'h0001_0000);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [7:0] wr_addr_cnt();
    return status[23:16];
  endfunction

endmodule

// File: doc/fir_coeff_sequencer.md
Name: fir_coeff_sequencer

Overview:
- Sequences FIR coefficient updates written by software through two PPC-to-Simulink software registers: a packed data word holding two 16-bit taps, and a control word.
- Writes tap pairs into the shadow bank of a double-buffered coefficient RAM and clears that bank on request.
- Swaps the active and shadow banks on the next datapath vector boundary, so the FIR never runs on a half-updated set.
- Lives in the user_clk (Simulink fabric) domain, between the software registers and the FIR coefficient RAMs.

Parameters:
N_PAIRS, 32, number of tap pairs per bank
ADDR_W, 5, tap-pair address width; must equal clog2(N_PAIRS)
COEFF_W, 16, width of one coefficient

Ports:
user_clk  in  1  fabric clock; all logic on the rising edge
user_rst_n  in  1  asynchronous active-low reset
cfg_data  in  32  packed coefficients from the software register; [31:16]=even tap, [15:0]=odd tap
cfg_ctrl  in  32  control word: [ADDR_W-1:0]=pair address, [16]=write toggle, [17]=commit toggle, [18]=clear toggle
sync_in  in  1  one-cycle vector-boundary pulse from the FIR datapath
coef_we  out  1  shadow RAM write enable
coef_addr  out  ADDR_W  shadow RAM pair address
coef_wdata  out  2*COEFF_W  shadow RAM write data
coef_bank  out  1  bank currently being written; always equals ~active_bank
active_bank  out  1  bank the FIR reads
busy  out  1  high while state != IDLE or any event is pending
status  out  32  readback word for a software register

Behaviour:
- Reset: all outputs 0 except coef_bank=1. State=IDLE, counters cleared, pending flags cleared. Reset asserted mid-operation aborts immediately; an interrupted clear or armed swap is lost.
- Input stage: cfg_data and cfg_ctrl are registered once (stage q).
- Toggle events:
  - A toggle event is q[bit] differing from its previous registered value.
  - The detector is primed on the first cycle after reset release, so no events occur in the first 2 cycles.
  - Events come from software flipping a bit; level changes on other bits are ignored.
- Pending flags: each event type sets its one-deep pending flag.
  - A second event of a type already pending sets sticky ovf_err.
  - The event itself is dropped, and the first captured addr/data are kept.
- States:
  - IDLE
  - WRITE (1 cycle)
  - CLEAR (N_PAIRS cycles)
  - ARMED (wait for sync_in)
- IDLE, service priority when several flags are pending: clear > write > commit. Unserviced flags stay pending.
- WRITE:
  - coef_we=1 for exactly one cycle with the captured addr/data. Next state IDLE.
  - Latency: a cfg_ctrl[16] change sampled at edge E0 produces coef_we=1 in the cycle after edge E2.
- CLEAR:
  - coef_we=1 for N_PAIRS consecutive cycles, addr 0..N_PAIRS-1 ascending, wdata=0. Then IDLE.
  - Also clears ovf_err and arm_err.
- Commit: moves IDLE->ARMED.
- ARMED:
  - A sync_in high in the entry cycle is ignored.
  - The first later sync_in toggles active_bank and coef_bank at the next edge, increments swap_cnt, and returns to IDLE.
  - Write and clear events arriving while ARMED stay pending and are serviced after the swap.
  - A commit event while ARMED or while commit is pending sets sticky arm_err and is otherwise dropped.
- Counters (wrap silently):
  - wr_cnt: 8 bits, +1 per WRITE.
  - swap_cnt: 16 bits.
- status: [15:0]=swap_cnt, [23:16]=wr_cnt, [24]=busy, [25]=ARMED, [26]=ovf_err, [27]=arm_err, [28]=active_bank, others 0. Registered; updates 1 cycle after the underlying state.
- Address out of range: if N_PAIRS < 2^ADDR_W, a write with addr >= N_PAIRS is suppressed (no coef_we) and sets ovf_err.

Decomposition:
- Package fir_seq_pkg holds:
  - the state enum
  - cfg_ctrl bit positions (WR_TGL=16, COMMIT_TGL=17, CLEAR_TGL=18)
  - status field positions
- One natural sub-module: tgl_event_det, a 3-bit registered toggle-change detector with post-reset priming, instantiated once.

Test Plan:
- Write: reset, cfg_data=0x1234ABCD, cfg_ctrl=0x00010007 -> one coef_we pulse, coef_addr=7, coef_wdata=0x1234ABCD, 2 cycles after the sampling edge; wr_cnt=1.
- Clear: toggle bit 18 -> 32 consecutive coef_we, addr 0..31, wdata=0, busy high throughout; ovf_err/arm_err cleared.
- Commit: toggle bit 17, sync_in at entry cycle then 5 cycles later -> first pulse ignored; active_bank 0->1 and coef_bank 1->0 after the second; swap_cnt=1.
- Simultaneous events: write and clear toggles in the same cycle -> 32 clear writes first, then the pair write; no ovf_err. A second write toggle during the clear -> ovf_err=1, the first captured data is written.
- Commit while armed: commit, second commit toggle before sync_in -> arm_err=1, exactly one swap. A write toggle while ARMED -> coef_we only after the swap, targeting the new shadow bank.
- Reset: assert user_rst_n=0 mid-clear (addr 12) -> coef_we=0, active_bank=0 at once. Release with cfg_ctrl toggle bits =1 -> no spurious events.
